// File: rtl/bus_datapath.sv
// Register-and-bus datapath of the 8-bit breadboard CPU: OR-resolved bus, PC, MAR, 16x8 RAM, IR, A/B, ALU, output register.
// Optional build macro BUS_DATAPATH_CONTENTION_EN adds a sticky bus contention flag on bus_err.
module bus_datapath #(
  parameter int RAM_DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       hlt,
  input  logic       mi,
  input  logic       ri,
  input  logic       ro,
  input  logic       io,
  input  logic       ii,
  input  logic       ai,
  input  logic       ao,
  input  logic       sumo,
  input  logic       sub,
  input  logic       bi,
  input  logic       oi,
  input  logic       ce,
  input  logic       co,
  input  logic       j,
  input  logic       prog_we,
  input  logic [3:0] prog_addr,
  input  logic [7:0] prog_data,
  output logic [7:0] insn,
  output logic [7:0] out_val,
  output logic       halted,
  output logic       alu_carry,
  output logic [7:0] bus_dbg,
  output logic       bus_err
);

  logic [7:0] ram_q [RAM_DEPTH];

  logic [3:0] pc_q, pc_d;
  logic [3:0] mar_q, mar_d;
  logic [7:0] ir_q, ir_d;
  logic [7:0] a_q, a_d;
  logic [7:0] b_q, b_d;
  logic [7:0] out_q, out_d;
  logic       halted_q, halted_d;

  logic [7:0] bus_s;
  logic [7:0] b_op_s;
  logic [8:0] sum_s;
  logic       ram_we_s;
  logic [3:0] ram_waddr_s;
  logic [7:0] ram_wdata_s;

  // Adder/subtractor: subtraction is A + ~B + 1, so carry out means A >= B.
  always_comb begin
    if (sub) begin
      b_op_s = ~b_q;
    end else begin
      b_op_s = b_q;
    end
    sum_s = {1'b0, a_q} + {1'b0, b_op_s} + {8'h00, sub};
  end

  // Bus resolution: every enabled driver is ORed in, an idle bus reads 0.
  always_comb begin
    bus_s = 8'h00;
    if (ro) begin
      bus_s = bus_s | ram_q[mar_q];
    end else begin
      bus_s = bus_s;
    end
    if (io) begin
      bus_s = bus_s | {4'h0, ir_q[3:0]};
    end else begin
      bus_s = bus_s;
    end
    if (ao) begin
      bus_s = bus_s | a_q;
    end else begin
      bus_s = bus_s;
    end
    if (sumo) begin
      bus_s = bus_s | sum_s[7:0];
    end else begin
      bus_s = bus_s;
    end
    if (co) begin
      bus_s = bus_s | {4'h0, pc_q};
    end else begin
      bus_s = bus_s;
    end
  end

  // Next-state for the control-line registers; everything freezes once halted.
  always_comb begin
    pc_d     = pc_q;
    mar_d    = mar_q;
    ir_d     = ir_q;
    a_d      = a_q;
    b_d      = b_q;
    out_d    = out_q;
    halted_d = halted_q | hlt;
    if (!halted_q) begin
      if (mi) begin
        mar_d = bus_s[3:0];
      end else begin
        mar_d = mar_q;
      end
      if (ii) begin
        ir_d = bus_s;
      end else begin
        ir_d = ir_q;
      end
      if (ai) begin
        a_d = bus_s;
      end else begin
        a_d = a_q;
      end
      if (bi) begin
        b_d = bus_s;
      end else begin
        b_d = b_q;
      end
      if (oi) begin
        out_d = bus_s;
      end else begin
        out_d = out_q;
      end
      if (j) begin
        pc_d = bus_s[3:0];
      end else if (ce) begin
        pc_d = pc_q + 4'd1;
      end else begin
        pc_d = pc_q;
      end
    end else begin
      pc_d = pc_q;
    end
  end

  // Single RAM write port: the program loader wins over ri and works even while halted or in reset.
  always_comb begin
    if (prog_we) begin
      ram_we_s    = 1'b1;
      ram_waddr_s = prog_addr;
      ram_wdata_s = prog_data;
    end else if (ri && !halted_q && !rst) begin
      ram_we_s    = 1'b1;
      ram_waddr_s = mar_q;
      ram_wdata_s = bus_s;
    end else begin
      ram_we_s    = 1'b0;
      ram_waddr_s = mar_q;
      ram_wdata_s = bus_s;
    end
  end

  // RAM array has no reset so program contents survive rst.
  always_ff @(posedge clk) begin
    if (ram_we_s) begin
      ram_q[ram_waddr_s] <= ram_wdata_s;
    end
  end

  // Architectural registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q     <= 4'h0;
      mar_q    <= 4'h0;
      ir_q     <= 8'h00;
      a_q      <= 8'h00;
      b_q      <= 8'h00;
      out_q    <= 8'h00;
      halted_q <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      mar_q    <= mar_d;
      ir_q     <= ir_d;
      a_q      <= a_d;
      b_q      <= b_d;
      out_q    <= out_d;
      halted_q <= halted_d;
    end
  end

`ifdef BUS_DATAPATH_CONTENTION_EN
  logic [2:0] drv_cnt_s;
  logic       bus_err_q, bus_err_d;

  // Count active bus drivers; two or more latch the sticky error regardless of halt.
  always_comb begin
    drv_cnt_s = {2'b00, ro} + {2'b00, io} + {2'b00, ao} + {2'b00, sumo} + {2'b00, co};
    bus_err_d = bus_err_q | (drv_cnt_s >= 3'd2);
  end

  // Sticky contention flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_err_q <= 1'b0;
    end else begin
      bus_err_q <= bus_err_d;
    end
  end

`ifndef SYNTHESIS
  // Simulation warning for each contention event.
  always_ff @(posedge clk) begin
    if (!rst && (drv_cnt_s >= 3'd2)) begin
      $display("bus_datapath: warning, %0d bus drivers active, bus=%02h", drv_cnt_s, bus_s);
    end
  end
`endif

  assign bus_err = bus_err_q;
`else
  assign bus_err = 1'b0;
`endif

  assign insn      = ir_q;
  assign out_val   = out_q;
  assign halted    = halted_q;
  assign alu_carry = sum_s[8];
  assign bus_dbg   = bus_s;

endmodule
